// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption sequencer: owns state reg, round counter and FSM; drives a shared inverse-round datapath.
// Latency: accept edge T -> out_valid after edge T+11; one block in flight, result held in DONE until out_ready.
// Backpressure: in_ready only in IDLE; optional abort input when AES_DEC_ABORT_EN is defined.
module aes_inv_round_ctrl #(
    parameter int NR       = 10,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_in,
    output logic [127:0]        dp_in,
    output logic                dp_last,
    input  logic [127:0]        dp_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
`ifdef AES_DEC_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } fsm_t;

    localparam logic [RK_IDX_W-1:0] RK_NR    = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] RK_NR_M1 = RK_IDX_W'(NR - 1);
    localparam logic [RK_IDX_W-1:0] RK_ONE   = RK_IDX_W'(1);

    fsm_t                fsm, fsm_nxt;
    logic [127:0]        st_q, st_nxt;
    logic [RK_IDX_W-1:0] round_q, round_nxt;
    logic                live_q;
    logic                abort_hit;

    // Abort only matters once a block is in flight; in IDLE it is ignored.
`ifdef AES_DEC_ABORT_EN
    assign abort_hit = abort && (fsm != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            st_q    <= '0;
            round_q <= '0;
            live_q  <= 1'b0;
        end else begin
            fsm     <= fsm_nxt;
            st_q    <= st_nxt;
            round_q <= round_nxt;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        fsm_nxt   = fsm;
        st_nxt    = st_q;
        round_nxt = round_q;
        in_ready  = (fsm == IDLE) && live_q;
        out_valid = 1'b0;
        rk_idx    = '0;
        dp_last   = 1'b0;
        unique case (fsm)
            IDLE: begin
                if (in_valid && live_q) begin
                    st_nxt    = in_data;
                    round_nxt = RK_NR;
                    fsm_nxt   = INIT;
                end
            end
            INIT: begin
                // Initial AddRoundKey is a plain XOR; the datapath output is not used here.
                rk_idx    = RK_NR;
                st_nxt    = st_q ^ rk_in;
                round_nxt = RK_NR_M1;
                fsm_nxt   = ROUND;
            end
            ROUND: begin
                rk_idx = round_q;
                st_nxt = dp_out;
                if (round_q == RK_ONE) begin
                    round_nxt = '0;
                    fsm_nxt   = FINAL;
                end else begin
                    round_nxt = round_q - RK_ONE;
                end
            end
            FINAL: begin
                dp_last = 1'b1;
                st_nxt  = dp_out;
                fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_nxt = IDLE;
                end
            end
            default: begin
                fsm_nxt = IDLE;
            end
        endcase
        // Abort outranks both the handoff and the round advance.
        if (abort_hit) begin
            fsm_nxt   = IDLE;
            st_nxt    = '0;
            round_nxt = '0;
            out_valid = 1'b0;
        end
    end

    assign dp_in    = st_q;
    assign out_data = out_valid ? st_q : '0;
    assign busy     = (fsm != IDLE);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: bench-side AES inverse-round datapath and key ROM, vector table, corner sequences, random run.
module tb_aes_inv_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in;
    logic [127:0] dp_in;
    logic         dp_last;
    logic [127:0] dp_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_DEC_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] rk_rom [11];

    aes_inv_round_ctrl #(.NR(10), .RK_IDX_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_in     (rk_in),
        .dp_in     (dp_in),
        .dp_last   (dp_last),
        .dp_out    (dp_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef AES_DEC_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-boxes from GF(2^8) inversion plus affine map, then FIPS-197 key expansion for key 000102..0f.
    task automatic build_tables();
        logic [7:0]   inv;
        logic [7:0]   s;
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [31:0]  w [44];
        logic [127:0] key;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[x]     = s;
            inv_sbox[s] = 8'(x);
        end
        key = 128'h000102030405060708090a0b0c0d0e0f;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_rom[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last).
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] t;
        logic [127:0] u;
        logic [7:0]   a0, a1, a2, a3;
        int           src;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
            t[127-8*i -: 8] = inv_sbox[s[127-8*src -: 8]];
        end
        t = t ^ k;
        u = t;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-32*c -: 8];
                a1 = t[119-32*c -: 8];
                a2 = t[111-32*c -: 8];
                a3 = t[103-32*c -: 8];
                u[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                u[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                u[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                u[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
        end
        return u;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk_rom[10];
        for (int r = 9; r >= 1; r--) s = inv_round(s, rk_rom[r], 1'b0);
        return inv_round(s, rk_rom[0], 1'b1);
    endfunction

    always @* begin
        rk_in = '0;
        if (int'(rk_idx) <= 10) rk_in = rk_rom[rk_idx];
        dp_out = inv_round(dp_in, rk_in, dp_last);
    end

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic send(input logic [127:0] ct);
        int n;
        in_valid = 1'b1;
        in_data  = ct;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk_b("accept_wait", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    // Full block with key-index trace, result check and a single-cycle handoff.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt);
        send(ct);
        for (int k = 0; k <= 10; k++) begin
            chk_i("rk_idx_trace", int'(rk_idx), 10 - k);
            chk_b("dp_last_trace", dp_last, k == 10);
            chk_b("busy_in_flight", busy, 1'b1);
            chk_b("no_early_valid", out_valid, 1'b0);
            tick();
        end
        chk_b("out_valid_at_11", out_valid, 1'b1);
        chk_v("plaintext", out_data, pt);
        chk_b("in_ready_done", in_ready, 1'b0);
        chk_i("rk_idx_done", int'(rk_idx), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_b("out_valid_after_handoff", out_valid, 1'b0);
        chk_b("in_ready_after_handoff", in_ready, 1'b1);
    endtask

    typedef struct {
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    initial begin
        vec_t         tbl [4];
        logic [127:0] ct_a, ct_b, held;
        int           t_a, t_b, got, seen;
        int           cnt;
        logic         pending, acc, xfer, exp_ov;
        logic [127:0] exp_pt;

        build_tables();
        tbl[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        tbl[1] = '{128'h0, 128'h0};
        tbl[2] = '{128'hffffffffffffffffffffffffffffffff, 128'h0};
        tbl[3] = '{128'h0123456789abcdeffedcba9876543210, 128'h0};
        for (int i = 1; i < 4; i++) tbl[i].pt = aes_dec(tbl[i].ct);

        // Reset values, in_ready held low until the first edge after release.
        #2;
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_dp_last", dp_last, 1'b0);
        chk_i("rst_rk_idx", int'(rk_idx), 0);
        chk_v("rst_out_data", out_data, 128'h0);
        chk_b("rst_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_b("in_ready_before_first_edge", in_ready, 1'b0);
        tick();
        chk_b("in_ready_after_release", in_ready, 1'b1);

        for (int i = 0; i < 4; i++) run_block(tbl[i].ct, tbl[i].pt);

        // Result held under backpressure, then a single out_ready pulse.
        send(tbl[3].ct);
        repeat (11) tick();
        for (int i = 0; i < 20; i++) begin
            chk_b("bp_valid_held", out_valid, 1'b1);
            chk_v("bp_data_held", out_data, tbl[3].pt);
            chk_b("bp_in_ready_low", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_b("bp_valid_drop", out_valid, 1'b0);
        chk_b("bp_in_ready_back", in_ready, 1'b1);

        // Back-to-back with in_valid held: IDLE, INIT, 9 ROUND, FINAL, DONE give 13 cycles between accepts.
        ct_a = tbl[0].ct;
        ct_b = tbl[2].ct;
        t_a = -1;
        t_b = -1;
        got = 0;
        in_valid  = 1'b1;
        in_data   = ct_a;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && t_b < 0; c++) begin
            if (out_valid) begin
                chk_v("b2b_first_pt", out_data, tbl[0].pt);
                chk_b("b2b_no_accept_in_done", in_ready, 1'b0);
                got++;
            end
            if (in_ready) begin
                if (t_a < 0) t_a = c;
                else t_b = c;
            end
            tick();
            if (t_a >= 0 && t_b < 0) in_data = ct_b;
        end
        in_valid = 1'b0;
        chk_i("b2b_first_handoffs", got, 1);
        chk_i("b2b_spacing", t_b - t_a, 13);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            if (out_valid) seen = 1;
            else tick();
        end
        chk_b("b2b_second_valid", out_valid, 1'b1);
        chk_v("b2b_second_pt", out_data, tbl[2].pt);
        tick();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of round 5.
        send(tbl[1].ct);
        repeat (5) tick();
        chk_i("mid_rst_round5", int'(rk_idx), 5);
        #3;
        rst_n = 1'b0;
        #1;
        chk_b("mid_rst_busy", busy, 1'b0);
        chk_b("mid_rst_out_valid", out_valid, 1'b0);
        chk_i("mid_rst_rk_idx", int'(rk_idx), 0);
        chk_b("mid_rst_dp_last", dp_last, 1'b0);
        chk_v("mid_rst_out_data", out_data, 128'h0);
        chk_b("mid_rst_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid || busy) seen = 1;
            tick();
        end
        chk_i("mid_rst_no_partial_output", seen, 0);
        run_block(tbl[0].ct, tbl[0].pt);

`ifdef AES_DEC_ABORT_EN
        // Abort during round 4, then abort while idle.
        send(tbl[0].ct);
        repeat (6) tick();
        chk_i("abort_round4", int'(rk_idx), 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_b("abort_busy", busy, 1'b0);
        chk_b("abort_in_ready", in_ready, 1'b1);
        chk_v("abort_out_data", out_data, 128'h0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) seen = 1;
            tick();
        end
        chk_i("abort_never_valid", seen, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_b("abort_idle_no_effect", in_ready, 1'b1);
        run_block(tbl[3].ct, tbl[3].pt);
`endif

        // Random traffic against a timeline model: a block is visible 11 cycles after its accept.
        pending = 1'b0;
        cnt     = 0;
        exp_pt  = '0;
        for (int c = 0; c < 600; c++) begin
            exp_ov = pending && (cnt >= 11);
            chk_b("rnd_in_ready", in_ready, !pending);
            chk_b("rnd_busy", busy, pending);
            chk_b("rnd_out_valid", out_valid, exp_ov);
            chk_i("rnd_rk_idx", int'(rk_idx), (pending && cnt <= 10) ? 10 - cnt : 0);
            chk_b("rnd_dp_last", dp_last, pending && cnt == 10);
            if (exp_ov) chk_v("rnd_plaintext", out_data, exp_pt);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            held = in_data;
            acc  = in_valid && !pending;
            xfer = exp_ov && out_ready;
            tick();
            if (pending) cnt++;
            if (xfer) pending = 1'b0;
            if (acc) begin
                pending = 1'b1;
                cnt     = 0;
                exp_pt  = aes_dec(held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
